// File: rtl/room_temp_model.sv
// room_temp_model
//
// Closed-loop room plant for the thermostat. It consumes the controller's
// heating/cooling outputs and produces the room temperature that feeds back
// into the controller's temperature inputs. Time is scaled by a prescaler.
// At each thermal step the temperature:
//   - rises by HEAT_RATE while heating,
//   - falls by COOL_RATE while cooling,
//   - drifts one degree toward AMBIENT every DRIFT_DIV idle steps.
//
// Ports:
//   clk         system clock, single domain
//   rst         synchronous active-high reset, highest priority
//   enable      1 = model runs, 0 = every counter, temperature and fault hold
//   heating     heater request, sampled only at a step edge
//   cooling     cooler request, sampled only at a step edge
//   temperature registered room temperature, unsigned degrees
//   tick        high for the one cycle in which a step result first appears
//   fault       sticky; set when heating and cooling are both high at a step
module room_temp_model #(
  parameter int TEMP_INIT = 20,
  parameter int TICK_DIV  = 4,
  parameter int HEAT_RATE = 1,
  parameter int COOL_RATE = 1,
  parameter int AMBIENT   = 16,
  parameter int DRIFT_DIV = 4,
  parameter int T_MIN     = 0,
  parameter int T_MAX     = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       heating,
  input  logic       cooling,
  output logic [4:0] temperature,
  output logic       tick,
  output logic       fault
);

  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;

  logic [PW-1:0] prescale;
  logic [DW-1:0] drift_cnt;
  logic          step;

  // A step edge is the last enabled cycle of each prescale period.
  assign step = enable && (prescale == PW'(TICK_DIV - 1));

  // Heating: 7-bit signed add so the sum cannot wrap before it is clamped.
  function automatic logic [4:0] sat_add(input logic [4:0] t);
    logic signed [6:0] s;
    s = $signed({2'b00, t}) + $signed(7'(HEAT_RATE));
    if (s > $signed(7'(T_MAX))) s = $signed(7'(T_MAX));
    return 5'(s);
  endfunction

  // Cooling: a negative intermediate is floored at T_MIN, never wrapped to 31.
  function automatic logic [4:0] sat_sub(input logic [4:0] t);
    logic signed [6:0] s;
    s = $signed({2'b00, t}) - $signed(7'(COOL_RATE));
    if (s < $signed(7'(T_MIN))) s = $signed(7'(T_MIN));
    return 5'(s);
  endfunction

  // Idle drift: one degree toward AMBIENT, none once it is reached.
  function automatic logic [4:0] toward_ambient(input logic [4:0] t);
    logic [6:0] w;
    w = {2'b00, t};
    if (w < 7'(AMBIENT))      return t + 5'd1;
    else if (w > 7'(AMBIENT)) return t - 5'd1;
    else                      return t;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      temperature <= 5'(TEMP_INIT);
      prescale    <= '0;
      drift_cnt   <= '0;
      tick        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (enable) begin
        prescale <= step ? '0 : prescale + PW'(1);
      end
      // Step boundary: sample the mode, publish the result with tick next cycle.
      if (step) begin
        tick <= 1'b1;
        unique case ({heating, cooling})
          2'b10: begin
            temperature <= sat_add(temperature);
            drift_cnt   <= '0;
          end
          2'b01: begin
            temperature <= sat_sub(temperature);
            drift_cnt   <= '0;
          end
          2'b11: begin
            drift_cnt <= '0;
            fault     <= 1'b1;
          end
          default: begin
            if (drift_cnt == DW'(DRIFT_DIV - 1)) begin
              temperature <= toward_ambient(temperature);
              drift_cnt   <= '0;
            end else begin
              drift_cnt <= drift_cnt + DW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_room_temp_model.sv
// Bench for room_temp_model: segments of held random inputs drive the DUT.
// Expected outputs are computed at the negedge before each active edge and
// queued; a monitor pops one entry after each edge and compares.
module tb_room_temp_model;

  localparam int TEMP_INIT = 20;
  localparam int TICK_DIV  = 4;
  localparam int HEAT_RATE = 1;
  localparam int COOL_RATE = 1;
  localparam int AMBIENT   = 16;
  localparam int DRIFT_DIV = 4;
  localparam int T_MIN     = 0;
  localparam int T_MAX     = 31;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       heating = 1'b0;
  logic       cooling = 1'b0;
  logic [4:0] temperature;
  logic       tick;
  logic       fault;

  room_temp_model #(
    .TEMP_INIT(TEMP_INIT), .TICK_DIV(TICK_DIV), .HEAT_RATE(HEAT_RATE),
    .COOL_RATE(COOL_RATE), .AMBIENT(AMBIENT), .DRIFT_DIV(DRIFT_DIV),
    .T_MIN(T_MIN), .T_MAX(T_MAX)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .heating(heating),
    .cooling(cooling), .temperature(temperature), .tick(tick), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] temp;
    logic       tk;
    logic       flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain integers, time measured in enabled cycles.
  int m_temp;
  int m_enabled;   // enabled cycles since the last reset
  int m_idle;      // consecutive idle steps not yet converted to drift
  bit m_fault;
  bit m_tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Apply one cycle of inputs and predict the outputs after the next edge.
  task automatic drive(input bit r, input bit e, input bit h, input bit c);
    @(negedge clk);
    rst = r; enable = e; heating = h; cooling = c;
    if (r) begin
      m_temp = TEMP_INIT; m_enabled = 0; m_idle = 0; m_fault = 0; m_tick = 0;
    end else if (!e) begin
      m_tick = 0;
    end else begin
      m_enabled++;
      m_tick = (m_enabled % TICK_DIV) == 0;
      if (m_tick) begin
        if (h && c) begin
          m_fault = 1; m_idle = 0;
        end else if (h) begin
          m_temp = (m_temp + HEAT_RATE > T_MAX) ? T_MAX : m_temp + HEAT_RATE;
          m_idle = 0;
        end else if (c) begin
          m_temp = (m_temp - COOL_RATE < T_MIN) ? T_MIN : m_temp - COOL_RATE;
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == DRIFT_DIV) begin
            m_idle = 0;
            if (m_temp < AMBIENT) m_temp++;
            else if (m_temp > AMBIENT) m_temp--;
          end
        end
      end
    end
    exp_q.push_back('{temp: 5'(m_temp), tk: m_tick, flt: m_fault});
  endtask

  // Monitor: one expected entry per active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("temperature", 32'(temperature), 32'(e.temp));
        check("tick",        32'(tick),        32'(e.tk));
        check("fault",       32'(fault),       32'(e.flt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int len, sel;
    bit h, c, e;

    // Reset, then idle drift from 20 down to AMBIENT and holding there.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 80; i++) drive(0, 1, 0, 0);
    // Heating up into the T_MAX saturation.
    for (int i = 0; i < 80; i++) drive(0, 1, 1, 0);
    // Cooling all the way down to the T_MIN floor.
    for (int i = 0; i < 140; i++) drive(0, 1, 0, 1);
    // Idle drift back up toward AMBIENT.
    for (int i = 0; i < 300; i++) drive(0, 1, 0, 0);
    // Freeze for 10 cycles mid-count, then resume.
    drive(0, 1, 1, 0); drive(0, 1, 1, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 0);
    // Conflict sets a sticky fault; reset mid-step clears everything.
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 1);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0);
    drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    drive(1, 1, 1, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 1, 0);

    // Randomized segments of held inputs with occasional resets and freezes.
    for (int s = 0; s < 120; s++) begin
      len = $urandom_range(3, 40);
      sel = $urandom_range(0, 15);
      h = (sel < 5) || (sel == 15);
      c = (sel >= 5 && sel < 10) || (sel == 15);
      for (int i = 0; i < len; i++) begin
        e = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 3) == 0) begin
          // Mid-period input wiggle: only the value at the step edge matters.
          drive(($urandom_range(0, 199) == 0), e, 1'($urandom), 1'($urandom));
        end else begin
          drive(($urandom_range(0, 199) == 0), e, h, c);
        end
      end
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/room_temp_model.md
Name: room_temp_model

Overview:
- Closed-loop plant model: the other end of the thermostat interface. It consumes the controller's heating/cooling outputs and produces the 5-bit room temperature that feeds the controller's temperature inputs.
- Lets the thermostat be exercised end-to-end in simulation and on the board without external sensor stimulus.
- Time is scaled by a prescaler. Temperature moves by fixed rates while heating or cooling, and drifts toward ambient when idle.

Parameters:
TEMP_INIT, 20, temperature loaded on reset (T_MIN..T_MAX)
TICK_DIV, 4, clock cycles per thermal step (>=1)
HEAT_RATE, 1, degrees added per step while heating
COOL_RATE, 1, degrees subtracted per step while cooling
AMBIENT, 16, idle drift target
DRIFT_DIV, 4, idle steps per one-degree drift (>=1)
T_MIN, 0, lower saturation bound
T_MAX, 31, upper saturation bound (<=31)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
enable  input  1  high = model runs; low = freeze all counters and temperature
heating  input  1  heater on, from the thermostat
cooling  input  1  cooler on, from the thermostat
temperature  output  5  current room temperature, registered, unsigned degrees
tick  output  1  one-cycle pulse, high in the cycle a step result first appears on temperature
fault  output  1  sticky; set when heating and cooling are both high at a step

Behaviour:
- Reset, sampled on the rising edge of clk with rst=1:
  - temperature=TEMP_INIT, prescaler=0, drift counter=0, tick=0, fault=0.
  - rst has priority over every other input.
  - Reset mid-step discards the partial prescale count.
- Prescaler: counts 0..TICK_DIV-1 while enable=1, then wraps to 0.
  - Step edge = the rising edge where enable=1 and prescaler==TICK_DIV-1.
- enable=0: prescaler, drift counter, temperature and fault all hold; tick=0.
- heating, cooling and the mode are sampled only at a step edge. The new temperature is visible after that edge, so latency is 1 cycle from the sampling edge.
- tick=1 for exactly the cycle following each step edge, even when temperature does not change (saturated or held).
- Step actions, selected by mode:
  - HEAT (heating=1, cooling=0): temperature = min(temperature+HEAT_RATE, T_MAX); drift counter cleared.
  - COOL (cooling=1, heating=0): temperature = max(temperature-COOL_RATE, T_MIN); drift counter cleared.
  - IDLE (both 0): if drift counter==DRIFT_DIV-1, move temperature one degree toward AMBIENT (no change if equal) and clear the counter; otherwise increment the counter.
  - CONFLICT (both 1): temperature held, drift counter cleared, fault set.
- fault stays 1 until rst, independent of later inputs.
- Arithmetic: compute in 7 bits. The add saturates at T_MAX and the subtract floors at T_MIN, so there is no wrap-around at 0 or 31.
- Mode changes between step edges have no effect; only the value at the step edge counts.
- TICK_DIV=1: every enabled edge is a step edge and tick stays high continuously.

Test Plan:
- Reset: rst=1 for 2 cycles, then enable=1, heating=cooling=0 -> temperature=20, tick=0, fault=0 immediately after reset; first tick 4 cycles after the first enabled edge.
- Heating: heating=1 for 12 enabled cycles -> temperature 21, 22, 23 after the 4th, 8th and 12th edges; tick pulses exactly 3 times, each one cycle wide.
- Saturation: TEMP_INIT=29, heating=1 for 5 steps -> 30, 31, 31, 31, 31, tick still on every step. Then cooling=1 from T_MIN+1 -> floors at 0, never wraps to 31.
- Idle drift: from 20, inputs low, run 64 cycles -> temperature 19 after step 4, then 18, 17, 16, holding at 16. Start from 10 -> rises to 16.
- Conflict: heating=cooling=1 at a step edge -> fault=1, temperature unchanged. Drop both -> fault stays 1 until rst=1 clears it.
- Freeze and reset mid-step: enable=0 for 10 cycles mid-count -> temperature and tick frozen, then resumes from the same prescale count. rst=1 at prescaler=2 -> temperature=TEMP_INIT and the next step occurs a full 4 cycles later.
